// File: rtl/pixel_fetch.sv
// Pixel fetch engine: pops pixel addresses from an address FIFO, reads the
// addressed byte from a 16-bit asynchronous SRAM (or substitutes a blank
// pixel for invalid addresses) and pushes one pixel at a time into the
// display FIFO. Counts pixels per frame and pulses a frame-done flag.
module pixel_fetch #(
  parameter int unsigned SRAM_LATENCY = 2,          // 1..7 cycles of held read
  parameter logic [7:0]  BLANK_PIXEL  = 8'h00,      // value for invalid addresses
  parameter int unsigned FRAME_PIXELS = 384000      // 800x480
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        iENABLE,
  input  logic        iADDR_READY_N,
  input  logic [19:0] iADDRESS,
  output logic        oADDR_READ,
  output logic [17:0] oSRAM_ADDR,
  output logic        oSRAM_CE_N,
  output logic        oSRAM_OE_N,
  output logic        oSRAM_WE_N,
  input  logic [15:0] iSRAM_DQ,
  output logic [7:0]  oPIX_DATA,
  output logic        oPIX_WRITE,
  input  logic        iPIX_FULL,
  output logic        oFRAME_DONE,
  output logic        oBUSY
);

  typedef enum logic [1:0] {
    StIdle,
    StLatch,
    StRead,
    StPush
  } state_e;

  // Read-hold counter preload: counts down to zero on the last READ cycle.
  localparam logic [2:0]  LatInit = 3'(SRAM_LATENCY - 1);
  localparam logic [18:0] CntLast = 19'(FRAME_PIXELS - 1);

  state_e      state_q, state_d;
  logic        ready_q;          // pops allowed only from the cycle after reset release
  logic        sel_q, sel_d;     // byte select: latched address bit 0
  logic [17:0] sram_addr_q, sram_addr_d;
  logic [2:0]  lat_q, lat_d;
  logic [7:0]  pix_q, pix_d;
  logic [18:0] cnt_q, cnt_d;
  logic        done_q, done_d;

  logic        addr_read;
  logic        pix_write;
  logic        sram_en;

  // Next-state, datapath updates and strobe decode for the one-pixel pipeline.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    sram_addr_d = sram_addr_q;
    lat_d       = lat_q;
    pix_d       = pix_q;
    cnt_d       = cnt_q;
    done_d      = 1'b0;
    addr_read   = 1'b0;
    pix_write   = 1'b0;
    sram_en     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (ready_q && iENABLE && !iADDR_READY_N) begin
          addr_read = 1'b1;
          state_d   = StLatch;
        end
      end

      StLatch: begin
        // FIFO data is valid one cycle after the pop.
        sel_d = iADDRESS[0];
        if (iADDRESS[19]) begin
          sram_addr_d = iADDRESS[18:1];
          lat_d       = LatInit;
          state_d     = StRead;
        end else begin
          pix_d   = BLANK_PIXEL;
          state_d = StPush;
        end
      end

      StRead: begin
        sram_en = 1'b1;
        if (lat_q == 3'd0) begin
          pix_d   = sel_q ? iSRAM_DQ[15:8] : iSRAM_DQ[7:0];
          state_d = StPush;
        end else begin
          lat_d = lat_q - 3'd1;
        end
      end

      StPush: begin
        if (!iPIX_FULL) begin
          pix_write = 1'b1;
          state_d   = StIdle;
          if (cnt_q == CntLast) begin
            cnt_d  = '0;
            done_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 19'd1;
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q     <= StIdle;
      ready_q     <= 1'b0;
      sel_q       <= 1'b0;
      sram_addr_q <= '0;
      lat_q       <= '0;
      pix_q       <= '0;
      cnt_q       <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ready_q     <= 1'b1;
      sel_q       <= sel_d;
      sram_addr_q <= sram_addr_d;
      lat_q       <= lat_d;
      pix_q       <= pix_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
    end
  end

  // Output drive; SRAM strobes are only active while the read is held.
  always_comb begin
    oADDR_READ  = addr_read;
    oPIX_WRITE  = pix_write;
    oPIX_DATA   = pix_q;
    oSRAM_ADDR  = sram_addr_q;
    oSRAM_CE_N  = ~sram_en;
    oSRAM_OE_N  = ~sram_en;
    oSRAM_WE_N  = 1'b1;
    oFRAME_DONE = done_q;
    oBUSY       = (state_q != StIdle);
  end

endmodule

// File: tb/tb_pixel_fetch.sv
// Self-checking bench for pixel_fetch: address FIFO and SRAM models, a
// scoreboard of expected pixels, a table of directed vectors and a few
// hand-written sequences (enable gating, reset mid-read, frame wrap).
module tb_pixel_fetch;

  localparam int unsigned L     = 2;
  localparam logic [7:0]  BLANK = 8'h00;
  localparam int unsigned FRAME = 4;

  logic        CLK, RESET_N, iENABLE, iADDR_READY_N, iPIX_FULL;
  logic [19:0] iADDRESS;
  logic [15:0] iSRAM_DQ;
  logic        oADDR_READ, oSRAM_CE_N, oSRAM_OE_N, oSRAM_WE_N;
  logic        oPIX_WRITE, oFRAME_DONE, oBUSY;
  logic [17:0] oSRAM_ADDR;
  logic [7:0]  oPIX_DATA;

  pixel_fetch #(
    .SRAM_LATENCY(L),
    .BLANK_PIXEL (BLANK),
    .FRAME_PIXELS(FRAME)
  ) dut (
    .CLK          (CLK),
    .RESET_N      (RESET_N),
    .iENABLE      (iENABLE),
    .iADDR_READY_N(iADDR_READY_N),
    .iADDRESS     (iADDRESS),
    .oADDR_READ   (oADDR_READ),
    .oSRAM_ADDR   (oSRAM_ADDR),
    .oSRAM_CE_N   (oSRAM_CE_N),
    .oSRAM_OE_N   (oSRAM_OE_N),
    .oSRAM_WE_N   (oSRAM_WE_N),
    .iSRAM_DQ     (iSRAM_DQ),
    .oPIX_DATA    (oPIX_DATA),
    .oPIX_WRITE   (oPIX_WRITE),
    .iPIX_FULL    (iPIX_FULL),
    .oFRAME_DONE  (oFRAME_DONE),
    .oBUSY        (oBUSY)
  );

  typedef struct {
    logic [19:0] addr;
    logic [15:0] dq;
    int          full;
    logic [7:0]  pix;
    logic [17:0] sram;
  } vec_t;

  typedef struct {
    logic [7:0]  pix;
    logic [17:0] sram;
    logic        valid;
    int          lat;
    int          exp_cycle;
    int          stall;
  } exp_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [15:0] mem [16];
  logic [19:0] fifo [$];
  exp_t        exp_q [$];
  exp_t        cur;
  logic        cur_active = 1'b0;
  int          ce_cnt = 0;
  int          model_cnt = 0;
  logic [17:0] model_sram = '0;
  logic        exp_done = 1'b0;
  logic        done_now;
  logic        pop_ok;
  int          fd_count = 0;
  logic        pend = 1'b0;
  logic        stale = 1'b0;
  logic [19:0] pend_addr = '0;

  // SRAM answers only while both strobes are low; junk otherwise.
  assign iSRAM_DQ = (!oSRAM_CE_N && !oSRAM_OE_N) ? mem[oSRAM_ADDR[3:0]] : 16'h5A5A;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic exp_t mk_exp(input logic [19:0] a);
    exp_t e;
    logic [15:0] w;
    w           = mem[a[4:1]];
    e.valid     = a[19];
    e.pix       = a[19] ? (a[0] ? w[15:8] : w[7:0]) : BLANK;
    e.sram      = a[18:1];
    e.lat       = a[19] ? 2 + int'(L) : 2;
    e.exp_cycle = 0;
    e.stall     = 0;
    return e;
  endfunction

  // Address FIFO model: data appears the cycle after the pop, then goes stale.
  always @(posedge CLK) begin
    #1;
    if (pend) begin
      iADDRESS = pend_addr;
      pend     = 1'b0;
      stale    = 1'b1;
    end else if (stale) begin
      iADDRESS = 20'h7FFFF;
      stale    = 1'b0;
    end
    iADDR_READY_N = (fifo.size() == 0);
  end

  // Output monitor and scoreboard, sampled mid-cycle.
  always @(negedge CLK) begin
    if (RESET_N) begin
      done_now = exp_done;
      exp_done = 1'b0;
      if (oFRAME_DONE || done_now) begin
        chk("frame_done", 32'(oFRAME_DONE), 32'(done_now));
        if (oFRAME_DONE) fd_count++;
      end
      chk("busy", 32'(oBUSY), 32'(cur_active));
      chk("we_n", 32'(oSRAM_WE_N), 32'd1);
      chk("oe_n", 32'(oSRAM_OE_N), 32'(oSRAM_CE_N));
      if (!oSRAM_CE_N) begin
        chk("read_allowed", 32'(cur_active && cur.valid), 32'd1);
        chk("sram_addr", 32'(oSRAM_ADDR), 32'(cur.sram));
        model_sram = cur.sram;
        ce_cnt++;
      end else begin
        chk("sram_addr_hold", 32'(oSRAM_ADDR), 32'(model_sram));
      end
      pop_ok = 1'b0;
      if (oADDR_READ) begin
        chk("pop_allowed", 32'(!cur_active && iENABLE && !iADDR_READY_N), 32'd1);
        pop_ok = !cur_active && (fifo.size() != 0) && (exp_q.size() != 0);
      end
      if (oPIX_WRITE) begin
        chk("write_expected", 32'(cur_active), 32'd1);
        chk("write_not_full", 32'(iPIX_FULL), 32'd0);
        if (cur_active) begin
          chk("pix_data", 32'(oPIX_DATA), 32'(cur.pix));
          chk("write_cycle", 32'(cyc), 32'(cur.exp_cycle + cur.stall));
          chk("read_cycles", 32'(ce_cnt), cur.valid ? 32'(L) : 32'd0);
        end
        model_cnt++;
        if (model_cnt == int'(FRAME)) begin
          model_cnt = 0;
          exp_done  = 1'b1;
        end
        cur_active = 1'b0;
      end else if (cur_active && cyc >= cur.exp_cycle + cur.stall) begin
        if (iPIX_FULL) begin
          chk("hold_data", 32'(oPIX_DATA), 32'(cur.pix));
          cur.stall++;
        end else begin
          chk("write_missing", 32'(cyc), 32'(cur.exp_cycle + cur.stall - 1));
          cur_active = 1'b0;
        end
      end
      if (pop_ok) begin
        cur           = exp_q.pop_front();
        cur.exp_cycle = cyc + cur.lat;
        cur.stall     = 0;
        cur_active    = 1'b1;
        ce_cnt        = 0;
        pend_addr     = fifo.pop_front();
        pend          = 1'b1;
      end
    end
  end

  task automatic push_pix(input logic [19:0] a, input logic [7:0] pix, input logic [17:0] sram);
    exp_t e;
    e.pix       = pix;
    e.sram      = sram;
    e.valid     = a[19];
    e.lat       = a[19] ? 2 + int'(L) : 2;
    e.exp_cycle = 0;
    e.stall     = 0;
    exp_q.push_back(e);
    fifo.push_back(a);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((cur_active || exp_q.size() != 0) && n < 400) begin
      @(posedge CLK);
      n++;
    end
    #1;
    chk("drain", 32'(cur_active || exp_q.size() != 0), 32'd0);
  endtask

  task automatic flush_model();
    exp_q.delete();
    fifo.delete();
    pend       = 1'b0;
    cur_active = 1'b0;
    model_cnt  = 0;
    model_sram = '0;
    exp_done   = 1'b0;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_addr_read", 32'(oADDR_READ), 32'd0);
    chk("rst_pix_write", 32'(oPIX_WRITE), 32'd0);
    chk("rst_frame_done", 32'(oFRAME_DONE), 32'd0);
    chk("rst_busy", 32'(oBUSY), 32'd0);
    chk("rst_ce_n", 32'(oSRAM_CE_N), 32'd1);
    chk("rst_oe_n", 32'(oSRAM_OE_N), 32'd1);
    chk("rst_we_n", 32'(oSRAM_WE_N), 32'd1);
    chk("rst_sram_addr", 32'(oSRAM_ADDR), 32'd0);
    chk("rst_pix_data", 32'(oPIX_DATA), 32'd0);
  endtask

  task automatic do_reset();
    RESET_N = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk_reset_outputs();
    flush_model();
    RESET_N = 1'b1;
  endtask

  vec_t vecs [8];
  exp_t e;
  int   n;

  initial begin
    vecs[0] = '{addr: 20'h80002, dq: 16'hBEEF, full: 0,  pix: 8'hEF, sram: 18'h00001};
    vecs[1] = '{addr: 20'h80003, dq: 16'hBEEF, full: 0,  pix: 8'hBE, sram: 18'h00001};
    vecs[2] = '{addr: 20'h00005, dq: 16'h0000, full: 0,  pix: 8'h00, sram: 18'h00000};
    vecs[3] = '{addr: 20'h8A5A8, dq: 16'h1234, full: 0,  pix: 8'h34, sram: 18'h052D4};
    vecs[4] = '{addr: 20'hFFFFF, dq: 16'hCAFE, full: 0,  pix: 8'hCA, sram: 18'h3FFFF};
    vecs[5] = '{addr: 20'h80011, dq: 16'h9D3C, full: 10, pix: 8'h9D, sram: 18'h00008};
    vecs[6] = '{addr: 20'h7FFFF, dq: 16'h0000, full: 3,  pix: 8'h00, sram: 18'h00000};
    vecs[7] = '{addr: 20'h80000, dq: 16'h00FF, full: 0,  pix: 8'hFF, sram: 18'h00000};

    for (int i = 0; i < 16; i++) mem[i] = 16'h1111 * 16'(i) ^ 16'h0F30;
    iENABLE       = 1'b1;
    iADDR_READY_N = 1'b1;
    iADDRESS      = 20'h7FFFF;
    iPIX_FULL     = 1'b0;
    do_reset();

    // Directed vectors, one pixel at a time, optional backpressure in PUSH.
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].addr[19]) mem[vecs[i].addr[4:1]] = vecs[i].dq;
      if (vecs[i].full > 0) iPIX_FULL = 1'b1;
      push_pix(vecs[i].addr, vecs[i].pix, vecs[i].sram);
      if (vecs[i].full > 0) begin
        // A second address waiting in the FIFO must not be popped while stalled.
        if (i + 1 < 8) begin
          if (vecs[i + 1].addr[19]) mem[vecs[i + 1].addr[4:1]] = vecs[i + 1].dq;
          push_pix(vecs[i + 1].addr, vecs[i + 1].pix, vecs[i + 1].sram);
        end
        n = 0;
        while (!(cur_active && cyc >= cur.exp_cycle) && n < 100) begin
          @(posedge CLK);
          #1;
          n++;
        end
        chk("reach_push", 32'(n < 100), 32'd1);
        repeat (vecs[i].full) @(posedge CLK);
        #1;
        iPIX_FULL = 1'b0;
        if (i + 1 < 8) i++;
      end
      wait_idle();
    end

    // Deasserting enable mid-pixel finishes that pixel but blocks the next pop.
    push_pix(20'h80006, mk_exp(20'h80006).pix, 18'h00003);
    n = 0;
    while (!cur_active && n < 50) begin
      @(posedge CLK);
      #1;
      n++;
    end
    iENABLE = 1'b0;
    push_pix(20'h00009, BLANK, 18'h00004);
    repeat (12) @(posedge CLK);
    #1;
    chk("enable_block_fifo", 32'(fifo.size()), 32'd1);
    chk("enable_pixel_done", 32'(cur_active), 32'd0);
    iENABLE = 1'b1;
    wait_idle();

    // Reset during READ discards the pixel; the next pop works normally.
    push_pix(20'h8000C, mk_exp(20'h8000C).pix, 18'h00006);
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (oSRAM_CE_N && n < 50);
    chk("reach_read", 32'(oSRAM_CE_N), 32'd0);
    #1;
    RESET_N = 1'b0;
    @(posedge CLK);
    #1;
    chk_reset_outputs();
    flush_model();
    RESET_N = 1'b1;
    repeat (8) @(posedge CLK);
    #1;
    push_pix(20'h80003, mk_exp(20'h80003).pix, 18'h00001);
    wait_idle();

    // Frame wrap: 9 mixed pixels streamed back to back with random backpressure.
    do_reset();
    fd_count = 0;
    for (int k = 0; k < 9; k++) begin
      logic [19:0] a;
      a = (k % 3 == 2) ? {1'b0, 19'(k)} : {1'b1, 19'(k * 3)};
      e = mk_exp(a);
      push_pix(a, e.pix, e.sram);
    end
    n = 0;
    while ((cur_active || exp_q.size() != 0) && n < 500) begin
      @(posedge CLK);
      #1;
      iPIX_FULL = ($urandom_range(0, 2) == 0);
      n++;
    end
    iPIX_FULL = 1'b0;
    wait_idle();
    repeat (2) @(posedge CLK);
    #1;
    chk("frame_pulses", 32'(fd_count), 32'd2);
    chk("frame_residue", 32'(model_cnt), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
